torture_checker: RTL

- Self-checking receiver for the torture XOR chain.
- Samples four adjacent chain taps, chain[k-3..k], and re-evaluates the recurrence chain[k](t+1) = chain[k-3](t) ^ chain[k-2](t) ^ chain[k-1](t) every cycle.
- Counts recurrence violations and watches the tail tap for stuck-at behaviour.
- Drives a status LED so a board under torture load reports pass/fail without a debugger.

---
 rtl/torture_checker.sv | 121 ++++++++++++
 1 files changed

// File: rtl/torture_checker.sv
// Self-checking receiver for the torture XOR chain: re-evaluates the tap
// recurrence every cycle, counts violations, flags a stuck tail and drives a status LED.
module torture_checker #(
   parameter int CNT_W         = 16,
   parameter int WARMUP_CYCLES = 64,
   parameter int ERR_LIMIT     = 8,
   parameter int WINDOW_CYCLES = 1024,
   parameter int MIN_TOGGLES   = 4,
   parameter int HB_BIT        = 23
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             enable,
   input  logic [3:0]       tap_in,
   output logic [CNT_W-1:0] err_count,
   output logic             error,
   output logic             fail,
   output logic             stuck,
   output logic             checking,
   output logic             led
);

   localparam int WARM_W = $clog2(WARMUP_CYCLES + 1);
   localparam int WIN_W  = $clog2(WINDOW_CYCLES);
   localparam int TOG_W  = (MIN_TOGGLES < 1) ? 1 : $clog2(MIN_TOGGLES + 1);

   localparam logic [1:0] ST_IDLE   = 2'd0;
   localparam logic [1:0] ST_WARMUP = 2'd1;
   localparam logic [1:0] ST_CHECK  = 2'd2;
   localparam logic [1:0] ST_FAIL   = 2'd3;

   logic [1:0]       state, state_nxt;
   logic [WARM_W-1:0] warm_cnt;
   logic [WIN_W-1:0] win_cnt;
   logic [TOG_W-1:0] tog_cnt, tog_inc;
   logic [HB_BIT:0]  hb_cnt;
   logic [2:0]       prev_taps;
   logic             prev_t3, prev_valid;
   logic             expected, mismatch, err_sat, err_hit, toggle;

   always_comb begin
      // NOTE: every signal gets a default first so no path can infer a latch.
      state_nxt = state;
      expected  = ^prev_taps;
      mismatch  = (state == ST_CHECK) && prev_valid && (tap_in[3] != expected);
      err_sat   = &err_count;
      err_hit   = mismatch && !err_sat && (err_count == CNT_W'(ERR_LIMIT - 1));
      toggle    = tap_in[3] ^ prev_t3;
      tog_inc   = (toggle && (tog_cnt != TOG_W'(MIN_TOGGLES))) ? tog_cnt + 1'b1 : tog_cnt;

      case (state)
         ST_IDLE:   if (enable) state_nxt = ST_WARMUP;
         ST_WARMUP: begin
            if (!enable)                                      state_nxt = ST_IDLE;
            else if (warm_cnt == WARM_W'(WARMUP_CYCLES - 1))  state_nxt = ST_CHECK;
         end
         // Reaching the error limit wins over a simultaneous enable drop.
         ST_CHECK: begin
            if (err_hit)      state_nxt = ST_FAIL;
            else if (!enable) state_nxt = ST_IDLE;
         end
         default:   state_nxt = ST_FAIL;
      endcase

      case (state)
         ST_IDLE:  led = 1'b0;
         ST_FAIL:  led = 1'b1;
         default:  led = stuck ? ~hb_cnt[HB_BIT-1] : hb_cnt[HB_BIT];
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= ST_IDLE;
         checking   <= 1'b0;
         fail       <= 1'b0;
         err_count  <= '0;
         error      <= 1'b0;
         stuck      <= 1'b0;
         warm_cnt   <= '0;
         win_cnt    <= '0;
         tog_cnt    <= '0;
         hb_cnt     <= '0;
         prev_taps  <= '0;
         prev_t3    <= 1'b0;
         prev_valid <= 1'b0;
      end else begin
         // NOTE: non-blocking assignments so every register samples pre-edge values.
         state      <= state_nxt;
         checking   <= (state_nxt == ST_CHECK);
         fail       <= (state_nxt == ST_FAIL);
         prev_taps  <= tap_in[2:0];
         prev_t3    <= tap_in[3];
         prev_valid <= (state == ST_WARMUP) || (state == ST_CHECK);
         hb_cnt     <= hb_cnt + 1'b1;

         if (mismatch && !err_sat) begin
            err_count <= err_count + 1'b1;
            error     <= 1'b1;
         end

         warm_cnt <= (state == ST_WARMUP) ? warm_cnt + 1'b1 : '0;

         // Only whole windows spent in CHECK are judged; anything else restarts the window.
         if ((state == ST_CHECK) && (state_nxt == ST_CHECK)) begin
            if (win_cnt == WIN_W'(WINDOW_CYCLES - 1)) begin
               if (tog_inc < TOG_W'(MIN_TOGGLES)) stuck <= 1'b1;
               win_cnt <= '0;
               tog_cnt <= '0;
            end else begin
               win_cnt <= win_cnt + 1'b1;
               tog_cnt <= tog_inc;
            end
         end else begin
            win_cnt <= '0;
            tog_cnt <= '0;
         end
      end
   end

endmodule
